// File: rtl/wb_arbiter_stage.sv
// wb_arbiter_stage
//   Write-back stage that merges the ALU result channel and the memory-load
//   channel onto the single register-file write port. Memory wins ties; an
//   ALU channel that keeps losing is forced through after STARVE_LIMIT
//   consecutive losses. Loads are lane-selected and sign/zero-extended before
//   they are registered. The registered write port feeds both the register
//   file and the forwarding unit.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   alu_valid/alu_ready           ALU channel handshake (ready is a grant)
//   alu_dst, alu_wb_en, alu_res   ALU destination, write enable, result
//   mem_valid/mem_ready           memory channel handshake (ready is a grant)
//   mem_dst, mem_wb_en, mem_data  load destination, write enable, raw word
//   mem_size, mem_signed          00 byte, 01 half, 1x word; sign/zero extend
//   mem_offset                    low address bits selecting the lane
//   WB_en, WB_Dest, WB_Value      registered register-file write port
//   wb_count                      count of issued WB_en pulses, wraps
module wb_arbiter_stage #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int STARVE_LIMIT   = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_dst,
  input  logic                      alu_wb_en,
  input  logic [WORD_WIDTH-1:0]     alu_res,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dst,
  input  logic                      mem_wb_en,
  input  logic [WORD_WIDTH-1:0]     mem_data,
  input  logic [1:0]                mem_size,
  input  logic                      mem_signed,
  input  logic [1:0]                mem_offset,
  output logic                      WB_en,
  output logic [REG_ADDR_WIDTH-1:0] WB_Dest,
  output logic [WORD_WIDTH-1:0]     WB_Value,
  output logic [CNT_WIDTH-1:0]      wb_count
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [WORD_WIDTH-1:0] ext_byte(input logic [7:0] b,
                                                     input logic sgn);
    logic signed [WORD_WIDTH-1:0] r;
    r = {{(WORD_WIDTH-8){sgn & b[7]}}, b};
    return r;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] ext_half(input logic [15:0] h,
                                                     input logic sgn);
    logic signed [WORD_WIDTH-1:0] r;
    r = {{(WORD_WIDTH-16){sgn & h[15]}}, h};
    return r;
  endfunction

  // Lanes always index the low 32 bits, even on wider datapaths.
  function automatic logic [WORD_WIDTH-1:0] fmt_load(input logic [WORD_WIDTH-1:0] data,
                                                     input logic [1:0] size,
                                                     input logic sgn,
                                                     input logic [1:0] off);
    logic [31:0]           low;
    logic [WORD_WIDTH-1:0] r;
    low = data[31:0];
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r = ext_byte(low[7:0],   sgn);
          2'd1:    r = ext_byte(low[15:8],  sgn);
          2'd2:    r = ext_byte(low[23:16], sgn);
          default: r = ext_byte(low[31:24], sgn);
        endcase
      end
      2'b01:   r = off[1] ? ext_half(low[31:16], sgn) : ext_half(low[15:0], sgn);
      default: r = data;
    endcase
    return r;
  endfunction

  logic [3:0]                starve_cnt;
  logic [3:0]                starve_nxt;
  logic                      force_alu;
  logic                      take_p0;
  logic                      sel_en_p0;
  logic [REG_ADDR_WIDTH-1:0] sel_dst_p0;
  logic [WORD_WIDTH-1:0]     sel_val_p0;

  // Stage p0: combinational grant and result selection
  always_comb begin
    force_alu  = (starve_cnt == LIMIT);
    // Grants are suppressed during reset so nothing is lost silently.
    mem_ready  = mem_valid & ~(force_alu & alu_valid) & ~rst;
    alu_ready  = alu_valid & ~mem_ready & ~rst;
    take_p0    = alu_ready | mem_ready;

    sel_en_p0  = 1'b0;
    sel_dst_p0 = alu_dst;
    sel_val_p0 = alu_res;
    if (mem_ready) begin
      sel_en_p0  = mem_wb_en;
      sel_dst_p0 = mem_dst;
      sel_val_p0 = fmt_load(mem_data, mem_size, mem_signed, mem_offset);
    end else if (alu_ready) begin
      sel_en_p0  = alu_wb_en;
    end

    starve_nxt = 4'd0;
    if (alu_valid & ~alu_ready)
      starve_nxt = force_alu ? LIMIT : starve_cnt + 4'd1;
  end

  // Stage p1: registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      WB_en      <= 1'b0;
      WB_Dest    <= '0;
      WB_Value   <= '0;
      wb_count   <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      WB_en      <= take_p0 & sel_en_p0;
      // Non-writing transfers leave the port contents untouched so the
      // forwarding unit keeps seeing the last real write.
      if (take_p0 & sel_en_p0) begin
        WB_Dest  <= sel_dst_p0;
        WB_Value <= sel_val_p0;
        wb_count <= wb_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter_stage.sv
module tb_wb_arbiter_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, alu_wb_en = 1'b0;
  logic [3:0]  alu_dst = '0;
  logic [31:0] alu_res = '0;
  logic        mem_valid = 1'b0, mem_wb_en = 1'b0, mem_signed = 1'b0;
  logic [3:0]  mem_dst = '0;
  logic [31:0] mem_data = '0;
  logic [1:0]  mem_size = '0, mem_offset = '0;
  logic        alu_ready, mem_ready, WB_en;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Value;
  logic [3:0]  wb_count;

  wb_arbiter_stage #(
    .WORD_WIDTH(32), .REG_ADDR_WIDTH(4), .STARVE_LIMIT(4), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst),
    .alu_wb_en(alu_wb_en), .alu_res(alu_res),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst),
    .mem_wb_en(mem_wb_en), .mem_data(mem_data), .mem_size(mem_size),
    .mem_signed(mem_signed), .mem_offset(mem_offset),
    .WB_en(WB_en), .WB_Dest(WB_Dest), .WB_Value(WB_Value), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [3:0]  dst;
    logic [31:0] val;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [3:0]  exp_cnt = '0;
  logic [3:0]  last_dst = '0;
  logic [31:0] last_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // g: expected grant (0 none, 1 alu, 2 mem); mval: hand-computed load value
  task automatic drive(input logic av, input logic [3:0] ad, input logic awe,
                       input logic [31:0] ares, input logic mv, input logic [3:0] md,
                       input logic mwe, input logic [31:0] mdat, input logic [1:0] msz,
                       input logic msg, input logic [1:0] moff, input int g,
                       input logic [31:0] mval);
    exp_t e;
    @(negedge clk);
    alu_valid = av; alu_dst = ad; alu_wb_en = awe; alu_res = ares;
    mem_valid = mv; mem_dst = md; mem_wb_en = mwe; mem_data = mdat;
    mem_size = msz; mem_signed = msg; mem_offset = moff;
    #1;
    chk("alu_ready", 32'(alu_ready), 32'(g == 1));
    chk("mem_ready", 32'(mem_ready), 32'(g == 2));
    e.en = 1'b0;
    if (g == 1 && awe) begin
      e.en = 1'b1; last_dst = ad; last_val = ares;
    end else if (g == 2 && mwe) begin
      e.en = 1'b1; last_dst = md; last_val = mval;
    end
    if (e.en) exp_cnt = exp_cnt + 4'd1;
    e.dst = last_dst; e.val = last_val; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic alu_only(input logic [3:0] d, input logic we, input logic [31:0] res);
    drive(1'b1, d, we, res, 1'b0, 4'd0, 1'b0, 32'h0, 2'b10, 1'b0, 2'd0, 1, 32'h0);
  endtask

  task automatic load(input logic [3:0] d, input logic [31:0] dat, input logic [1:0] sz,
                      input logic sg, input logic [1:0] off, input logic [31:0] want);
    drive(1'b0, 4'd0, 1'b0, 32'h0, 1'b1, d, 1'b1, dat, sz, sg, off, 2, want);
  endtask

  task automatic both(input int i, input int g);
    drive(1'b1, 4'(i), 1'b1, 32'h100 + i, 1'b1, 4'(i + 1), 1'b1, 32'h200 + i,
          2'b10, 1'b0, 2'd0, g, 32'h200 + i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    alu_valid = 1'b1; mem_valid = 1'b1; rst = 1'b1;
    #1;
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_WB_en", 32'(WB_en), 32'd0);
    chk("rst_WB_Dest", 32'(WB_Dest), 32'd0);
    chk("rst_WB_Value", WB_Value, 32'd0);
    chk("rst_wb_count", 32'(wb_count), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_mem_ready", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0; mem_valid = 1'b0; rst = 1'b0;
    exp_cnt = '0; last_dst = '0; last_val = '0;
  endtask

  // Monitor: the write port is presented one edge after each issued vector
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("WB_en", 32'(WB_en), 32'(e.en));
        chk("WB_Dest", 32'(WB_Dest), 32'(e.dst));
        chk("WB_Value", WB_Value, e.val);
        chk("wb_count", 32'(wb_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // First cycle after reset: memory wins the tie
    both(0, 2);
    // Single ALU write
    alu_only(4'd3, 1'b1, 32'h1234_5678);
    // Load extension on 0x80F1_7F82
    load(4'd4, 32'h80F1_7F82, 2'b00, 1'b1, 2'd0, 32'hFFFF_FF82);
    load(4'd5, 32'h80F1_7F82, 2'b00, 1'b0, 2'd1, 32'h0000_007F);
    load(4'd6, 32'h80F1_7F82, 2'b01, 1'b1, 2'd2, 32'hFFFF_80F1);
    load(4'd7, 32'h80F1_7F82, 2'b01, 1'b0, 2'd3, 32'h0000_80F1);
    load(4'd8, 32'h80F1_7F82, 2'b10, 1'b1, 2'd1, 32'h80F1_7F82);
    load(4'd9, 32'h80F1_7F82, 2'b11, 1'b1, 2'd2, 32'h80F1_7F82);
    load(4'd10, 32'h80F1_7F82, 2'b00, 1'b1, 2'd3, 32'hFFFF_FF80);
    load(4'd11, 32'h80F1_7F82, 2'b00, 1'b1, 2'd2, 32'hFFFF_FFF1);
    load(4'd12, 32'h80F1_7F82, 2'b01, 1'b1, 2'd0, 32'h0000_7F82);
    load(4'd13, 32'h80F1_7F82, 2'b01, 1'b0, 2'd1, 32'h0000_7F82);
    // Non-writing transfers: handshake but hold the port
    drive(1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 4'd14, 1'b0, 32'hDEAD_BEEF,
          2'b10, 1'b0, 2'd0, 2, 32'hDEAD_BEEF);
    alu_only(4'd15, 1'b0, 32'hCAFE_F00D);
    // Idle cycle
    drive(1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 32'h0, 2'b10, 1'b0, 2'd0, 0, 32'h0);
    // Contention: period-5 pattern, ALU forced on every fifth cycle
    for (int i = 0; i < 10; i++) both(i, (i % 5 == 4) ? 1 : 2);
    // Build starvation history, reset mid-stream, history must be gone
    for (int i = 0; i < 3; i++) both(i, 2);
    do_reset();
    for (int i = 0; i < 5; i++) both(i + 6, (i == 4) ? 1 : 2);
    // Counter wrap at CNT_WIDTH=4: 17 writes from zero end at 1
    do_reset();
    for (int i = 0; i < 17; i++) alu_only(4'(i), 1'b1, 32'h3000 + i);
    @(negedge clk);
    alu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("wrap_final_count", 32'(wb_count), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
